fir_down_sample: RTL and testbench
==================================

FIR_DOWN_SAMPLE -- requirements
Module: fir_down_sample

Interface
REQ-001 SHALL have parameter TCQ, default 0.1, the simulation delay on register assignments.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the sample width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the output buffer depth, a power of two ≥2.
REQ-004 Port clk_i  input  1  is the single clock.
REQ-005 Port rst_n_i  input  1  is the reset: asynchronous, active-low.
REQ-006 Port laser_start_i  input  1  is the acquisition enable level.
REQ-007 Port fir_down_sample_num_i  input  8  is the decimation parameter N; ratio R = N+1.
REQ-008 Port lp_laser_vld_i  input  1  is the low-pass sample strobe, one cycle.
REQ-009 Port lp_laser_data_i  input  DATA_WIDTH  is the low-pass sample.
REQ-010 Port ds_laser_rdy_i  input  1  is the downstream ready.
REQ-011 Port ds_laser_vld_o  output  1  is the decimated sample valid.
REQ-012 Port ds_laser_data_o  output  DATA_WIDTH  is the decimated sample.
REQ-013 Port ds_busy_o  output  1  is high while state ≠ IDLE.

Function
REQ-014 SHALL implement a state machine with states IDLE, RUN and DRAIN.
- IDLE→RUN on the laser_start_i rising edge.
- RUN→DRAIN on the falling edge when the FIFO is non-empty; RUN→IDLE on the falling edge when the FIFO is empty.
- DRAIN→IDLE when the FIFO becomes empty.
- DRAIN→RUN on a rising edge.
REQ-015 On every laser_start_i rising edge, SHALL do all of the following in the same cycle:
- latch N, with N>19 clamped to 19;
- clear the phase counter;
- flush the FIFO.
REQ-016 In RUN, each lp_laser_vld_i SHALL increment the phase counter (0..R-1). When the counter equals the latched N, the sample SHALL be kept and the counter SHALL wrap to 0; all other samples are discarded.
REQ-017 A sample arriving in the rising-edge cycle SHALL count as phase 0. It is kept immediately if N=0.
REQ-018 Strobes outside RUN SHALL be ignored.
REQ-019 A kept sample SHALL be written into the FIFO. When the FIFO is full it SHALL be dropped; the FIFO and its contents are unaffected.
REQ-020 The FIFO SHALL be first-word-fall-through. A kept sample SHALL appear on ds_laser_vld_o/ds_laser_data_o one cycle after the strobe when the FIFO was empty.
REQ-021 Transfer SHALL occur when vld and rdy are both high. ds_laser_data_o SHALL stay stable while vld is high and rdy is low.
REQ-022 A simultaneous write and read on a full FIFO SHALL both succeed.
REQ-023 A write and a flush in the same cycle: the flush SHALL win and the write SHALL be discarded.
REQ-024 N changes on fir_down_sample_num_i mid-run SHALL have no effect until the next rising edge.

Reset
REQ-025 With rst_n_i low, the block SHALL asynchronously hold:
- state at IDLE;
- phase counter and latched N at 0;
- FIFO empty;
- ds_laser_vld_o, ds_laser_data_o and ds_busy_o at 0.
REQ-026 Reset mid-operation SHALL discard buffered samples. After release, the block SHALL wait for a fresh rising edge, even if laser_start_i is already high.

Configuration
REQ-027 With FIR_DS_DROP_CNT_EN defined, the block SHALL provide output port ds_drop_cnt_o, 16 bits:
- counts samples dropped on FIFO full;
- saturates at 0xFFFF;
- clears on reset and on each rising edge.
REQ-028 Without FIR_DS_DROP_CNT_EN, the port and counter SHALL be absent and drop behaviour SHALL be unchanged.

Structure
REQ-029 Shared package fir_pkg SHALL hold:
- FIR_TAP_REPEAT = 20;
- FIR_DS_NUM_MAX = 19;
- the state enumeration typedef.
REQ-030 The FIFO SHALL be the sub-module ds_fwft_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH with a synchronous flush input. The state machine and phase counter SHALL reside in fir_down_sample.

Verification
REQ-031 Decimation at N=3, rdy=1: rising edge, then 12 strobes with data 1..12 → output 4, 8, 12, each one cycle after its strobe.
REQ-032 Clamp: N=40, 40 strobes with data 1..40 → output 20, 40.
REQ-033 Backpressure at N=0, rdy=0, 6 strobes with data 1..6 → FIFO holds 1..4; ds_drop_cnt_o=2 if enabled; on raising rdy, output 1, 2, 3, 4 with stable data while stalled.
REQ-034 Drain: N=0, rdy=0, 3 samples, then laser_start_i falls → state DRAIN with busy=1; rdy=1 → 3 outputs, then IDLE with busy=0.
REQ-035 Restart flush: FIFO holding 2 samples, laser_start_i low then high → FIFO empty, vld=0, phase restarted; a strobe in the edge cycle counts as phase 0.
REQ-036 Async reset: assert rst_n_i mid-RUN between clock edges → outputs 0 immediately; release with laser_start_i high → strobes ignored until the next rising edge.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimator path.
//   FIR_TAP_REPEAT : number of phases the phase counter can span
//   FIR_DS_NUM_MAX : largest decimation parameter N accepted (ratio N+1)
//   fir_ds_state_e : decimator control state
//   fir_ds_clamp   : saturates a raw 8-bit N to FIR_DS_NUM_MAX
package fir_pkg;

  localparam int FIR_TAP_REPEAT = 20;
  localparam int FIR_DS_NUM_MAX = 19;
  localparam int FIR_PH_W       = $clog2(FIR_TAP_REPEAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fir_ds_state_e;

  function automatic logic [FIR_PH_W-1:0] fir_ds_clamp(input logic [7:0] n);
    return (n > 8'(FIR_DS_NUM_MAX)) ? FIR_PH_W'(FIR_DS_NUM_MAX) : n[FIR_PH_W-1:0];
  endfunction

endpackage

// File: rtl/ds_fwft_fifo.sv
// First-word-fall-through buffer for decimated samples.
//   clk_i/rst_n_i : clock, async active-low reset
//   flush_i       : synchronous clear; wins over a same-cycle write or read
//   wr_en_i/wr_data_i : write request (ignored when full unless a read frees a slot)
//   rd_en_i       : consumer ready; pops the head when not empty
//   rd_data_o     : head word, zero while empty
//   empty_o/full_o: occupancy flags
module ds_fwft_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
)(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]           r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  w_wr, w_rd;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A read in the same cycle frees a slot, so a write into a full buffer still lands.
  assign w_rd = rd_en_i & ~empty_o & ~flush_i;
  assign w_wr = wr_en_i & (~full_o | w_rd) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data_i;
  end

  // Gate the head so the output bus reads zero while empty (including reset).
  assign rd_data_o = empty_o ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/fir_down_sample.sv
// Decimates the low-pass sample stream by R = N+1 and buffers kept samples
// in a small FWFT FIFO toward a valid/ready consumer.
//   clk_i, rst_n_i          : clock, async active-low reset
//   laser_start_i           : acquisition enable level; rising edge restarts
//   fir_down_sample_num_i   : N, latched (clamped to 19) on each rising edge
//   lp_laser_vld_i/_data_i  : input sample strobe and data
//   ds_laser_rdy_i          : downstream ready
//   ds_laser_vld_o/_data_o  : decimated sample out
//   ds_busy_o               : high while not IDLE
//   ds_drop_cnt_o           : saturating count of samples lost to a full FIFO
//                             (present only with FIR_DS_DROP_CNT_EN defined)
module fir_down_sample
  import fir_pkg::*;
#(
  parameter real TCQ        = 0.1,
  parameter int  DATA_WIDTH = 16,
  parameter int  FIFO_DEPTH = 4
)(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  laser_start_i,
  input  logic [7:0]            fir_down_sample_num_i,
  input  logic                  lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0] lp_laser_data_i,
  input  logic                  ds_laser_rdy_i,
  output logic                  ds_laser_vld_o,
  output logic [DATA_WIDTH-1:0] ds_laser_data_o,
  output logic                  ds_busy_o
`ifdef FIR_DS_DROP_CNT_EN
  ,
  output logic [15:0]           ds_drop_cnt_o
`endif
);

  // Register timing is modelled with zero delay; TCQ is kept for interface compatibility.
  localparam real UNUSED_TCQ = TCQ;

  fir_ds_state_e         r_state;
  logic                  r_busy;
  logic                  r_start_d;
  logic [FIR_PH_W-1:0]   r_n;
  logic [FIR_PH_W-1:0]   r_phase;

  logic                  w_rise, w_fall, w_active, w_take, w_keep;
  logic [FIR_PH_W-1:0]   w_cur_n, w_cur_phase;
  logic                  w_empty, w_full;

  assign w_rise = laser_start_i & ~r_start_d;
  assign w_fall = ~laser_start_i & r_start_d;

  // The rising-edge cycle already decimates with the freshly latched N and phase 0.
  assign w_active    = (r_state == ST_RUN) | w_rise;
  assign w_cur_n     = w_rise ? fir_ds_clamp(fir_down_sample_num_i) : r_n;
  assign w_cur_phase = w_rise ? '0 : r_phase;
  assign w_take      = lp_laser_vld_i & w_active;
  assign w_keep      = w_take & (w_cur_phase == w_cur_n);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      // Reset as "already high" so a level held through reset is not taken as an edge.
      r_start_d <= 1'b1;
      r_n       <= '0;
      r_phase   <= '0;
    end else begin
      r_start_d <= laser_start_i;
      if (w_rise) r_n <= w_cur_n;

      if (w_take)      r_phase <= w_keep ? '0 : w_cur_phase + FIR_PH_W'(1);
      else if (w_rise) r_phase <= '0;

      case (r_state)
        ST_IDLE: if (w_rise) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end
        ST_RUN: if (w_fall) begin
          // A sample written this very cycle still needs draining.
          if (w_empty & ~w_keep) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (w_rise) begin
          r_state <= ST_RUN;
        end else if (w_empty) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ds_busy_o = r_busy;

  // The restart flush discards a sample kept in the edge cycle.
  ds_fwft_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (w_rise),
    .wr_en_i   (w_keep),
    .wr_data_i (lp_laser_data_i),
    .rd_en_i   (ds_laser_rdy_i),
    .rd_data_o (ds_laser_data_o),
    .empty_o   (w_empty),
    .full_o    (w_full)
  );

  assign ds_laser_vld_o = ~w_empty;

`ifdef FIR_DS_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Full implies non-empty, so a concurrent pop happens exactly when ready is high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_drop_cnt <= '0;
    else if (w_rise)
      r_drop_cnt <= '0;
    else if (w_keep & w_full & ~ds_laser_rdy_i & (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign ds_drop_cnt_o = r_drop_cnt;
`else
  logic w_unused_full;
  assign w_unused_full = w_full;
`endif

endmodule

// File: tb/tb_fir_down_sample.sv
module tb_fir_down_sample;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    num;
  logic          lp_vld;
  logic [DW-1:0] lp_data;
  logic          rdy;
  logic          ds_vld;
  logic [DW-1:0] ds_data;
  logic          busy;
`ifdef FIR_DS_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  fir_down_sample dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .laser_start_i         (start),
    .fir_down_sample_num_i (num),
    .lp_laser_vld_i        (lp_vld),
    .lp_laser_data_i       (lp_data),
    .ds_laser_rdy_i        (rdy),
    .ds_laser_vld_o        (ds_vld),
    .ds_laser_data_o       (ds_data),
    .ds_busy_o             (busy)
`ifdef FIR_DS_DROP_CNT_EN
    , .ds_drop_cnt_o       (drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue for the buffer, integer phase/N, named modes.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  mstate_t       m_state;
  bit            m_prev;
  int            m_n, m_ph, m_drop;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit rise, fall, rd, run, keep;
    int sz0, n_eff, ph;
    if (!rst_n) begin
      m_state = M_IDLE;
      m_prev  = 1'b1;
      m_n     = 0;
      m_ph    = 0;
      m_drop  = 0;
      q.delete();
    end else begin
      rise  = start && !m_prev;
      fall  = !start && m_prev;
      sz0   = q.size();
      rd    = rdy && (sz0 != 0);
      run   = (m_state == M_RUN) || rise;
      n_eff = rise ? ((num > 8'd19) ? 19 : int'(num)) : m_n;
      ph    = rise ? 0 : m_ph;
      keep  = 1'b0;
      if (lp_vld && run) begin
        if (ph == n_eff) begin keep = 1'b1; ph = 0; end
        else ph = ph + 1;
      end
      m_ph   = ph;
      m_n    = n_eff;
      m_prev = start;
      case (m_state)
        M_IDLE:  if (rise) m_state = M_RUN;
        M_RUN:   if (fall) m_state = (sz0 == 0 && !keep) ? M_IDLE : M_DRAIN;
        M_DRAIN: if (rise) m_state = M_RUN; else if (sz0 == 0) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
      if (rise) begin
        q.delete();
        m_drop = 0;
      end else begin
        if (rd) void'(q.pop_front());
        if (keep) begin
          if (sz0 < DEPTH || rd) q.push_back(lp_data);
          else if (m_drop < 65535) m_drop = m_drop + 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, plus a log of transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", 32'(ds_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(ds_data), 32'd0);
    end else begin
      chk("vld", 32'(ds_vld), 32'(q.size() != 0));
      if (q.size() != 0) chk("data", 32'(ds_data), 32'(q[0]));
      chk("busy", 32'(busy), 32'(m_state != M_IDLE));
`ifdef FIR_DS_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
      if (ds_vld && rdy) got.push_back(ds_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    lp_vld  = 1'b1;
    lp_data = d;
    tick();
    lp_vld  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num = 8'd0; lp_vld = 1'b0; lp_data = '0; rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_vld", 32'(ds_vld), 32'd0);
    chk("reset_data", 32'(ds_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Decimate by 4: keep every fourth sample, visible the cycle after its strobe.
    num = 8'd3; start = 1'b1; tick();
    chk("run_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      strobe(DW'(k));
      if (k % 4 == 0) begin
        chk("dec4_vld", 32'(ds_vld), 32'd1);
        chk("dec4_data", 32'(ds_data), 32'(k));
      end
    end
    start = 1'b0; tick(); tick();
    chk("dec4_idle", 32'(busy), 32'd0);

    // N above the limit clamps to 19 -> every 20th sample.
    num = 8'd40; start = 1'b1; tick();
    got.delete();
    for (int k = 1; k <= 40; k++) strobe(DW'(k));
    tick();
    chk("clamp_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("clamp_first", 32'(got[0]), 32'd20);
      chk("clamp_second", 32'(got[1]), 32'd40);
    end
    start = 1'b0; tick(); tick();

    // Backpressure: four fit, two are dropped, head holds while stalled.
    rdy = 1'b0; num = 8'd0; start = 1'b1; tick();
    for (int k = 1; k <= 6; k++) strobe(DW'(k));
`ifdef FIR_DS_DROP_CNT_EN
    chk("bp_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_vld", 32'(ds_vld), 32'd1);
      chk("bp_stall_data", 32'(ds_data), 32'd1);
      tick();
    end
    got.delete();
    rdy = 1'b1;
    repeat (6) tick();
    chk("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("bp_order", 32'(got[i]), 32'(i + 1));
    start = 1'b0; tick(); tick();

    // Drain after the enable falls with samples still buffered.
    rdy = 1'b0; num = 8'd0; start = 1'b1; tick();
    strobe(DW'(7)); strobe(DW'(8)); strobe(DW'(9));
    start = 1'b0; tick();
    chk("drain_busy", 32'(busy), 32'd1);
    tick();
    chk("drain_hold", 32'(busy), 32'd1);
    got.delete();
    rdy = 1'b1;
    for (int i = 0; i < 12 && busy; i++) tick();
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("drain_order", 32'(got[i]), 32'(i + 7));

    // Restart flushes the buffer; the edge-cycle strobe is phase 0.
    rdy = 1'b0; num = 8'd1; start = 1'b1; tick();
    for (int k = 1; k <= 4; k++) strobe(DW'(k));
    chk("rs_pre_vld", 32'(ds_vld), 32'd1);
    start = 1'b0; tick();
    start = 1'b1; strobe(DW'(50));
    chk("rs_flushed", 32'(ds_vld), 32'd0);
    strobe(DW'(51));
    chk("rs_phase_vld", 32'(ds_vld), 32'd1);
    chk("rs_phase_data", 32'(ds_data), 32'd51);

    // Asynchronous reset mid-run; a held enable must not restart the block.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(ds_vld), 32'd0);
    chk("ar_data", 32'(ds_data), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    num = 8'd0; rdy = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      strobe(DW'(60 + k));
      chk("ar_ignored", 32'(ds_vld), 32'd0);
    end
    chk("ar_idle", 32'(busy), 32'd0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    rdy = 1'b0;
    strobe(DW'(77));
    chk("ar_restart_data", 32'(ds_data), 32'd77);
    rdy = 1'b1; tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) start = ~start;
      if ($urandom_range(0, 99) < 5) num = 8'($urandom_range(0, 24));
      if ($urandom_range(0, 499) == 0) num = 8'($urandom);
      lp_vld  = 1'($urandom_range(0, 1));
      lp_data = DW'($urandom);
      rdy     = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      tick();
    end
    lp_vld = 1'b0; rdy = 1'b1; start = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
